qm_decode: RTL and testbench

- Instruction decode stage (ID) of the 5-stage core.
- Accepts fetched instructions with a valid/ready handshake and splits the instruction fields.
- Reads a 32x32 register file that the writeback stage writes. Extends the immediate.
- Registers the results into the ID/EX pipeline register. o_Opcode and o_Function feed qm_control; the remaining outputs feed execute.
- Detects load-use hazards, and handles stalls and flushes.

---
 rtl/qm_decode.sv | 132 +++++++++++++
 tb/tb_qm_decode.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qm_decode.sv
// qm_decode: ID stage. Splits fields, reads the register file, extends the
// immediate and registers everything into the ID/EX register.
module qm_decode #(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_IFValid,
  output logic        o_IFReady,
  input  logic [31:0] i_Instruction,
  input  logic [31:0] i_PC,
  input  logic        i_Flush,
  input  logic        i_EXReady,
  input  logic        i_WBEnable,
  input  logic [4:0]  i_WBAddr,
  input  logic [31:0] i_WBData,
  output logic        o_Valid,
  output logic [5:0]  o_Opcode,
  output logic [5:0]  o_Function,
  output logic [4:0]  o_RS,
  output logic [4:0]  o_RT,
  output logic [4:0]  o_RD,
  output logic [31:0] o_RSData,
  output logic [31:0] o_RTData,
  output logic [31:0] o_Immediate,
  output logic [31:0] o_PC,
  output logic        o_LoadUseStall
);

  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  logic [31:0] rf [32];

  logic [5:0]  f_op;
  logic [5:0]  f_fn;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic        wb_live;
  logic        is_load;
  logic        hazard;
  logic        adv;
  logic        accept;

  assign f_op = i_Instruction[31:26];
  assign f_rs = i_Instruction[25:21];
  assign f_rt = i_Instruction[20:16];
  assign f_rd = i_Instruction[15:11];
  assign f_fn = i_Instruction[5:0];

  // A write to r0 is meaningless when r0 is hardwired, so it never bypasses
  assign wb_live = i_WBEnable && !(ZERO_REG && i_WBAddr == 5'd0);

  always_comb begin
    rs_val = rf[f_rs];
    if (wb_live && i_WBAddr == f_rs) rs_val = i_WBData;
    if (ZERO_REG && f_rs == 5'd0) rs_val = '0;
  end

  always_comb begin
    rt_val = rf[f_rt];
    if (wb_live && i_WBAddr == f_rt) rt_val = i_WBData;
    if (ZERO_REG && f_rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    imm_ext = {{16{i_Instruction[15]}}, i_Instruction[15:0]};
    if (f_op inside {OP_ANDI, OP_ORI, OP_XORI})
      imm_ext = {16'h0000, i_Instruction[15:0]};
  end

  assign is_load = o_Opcode inside {6'b100000, 6'b100001, 6'b100011,
                                    6'b100100, 6'b100101};

  assign hazard = o_Valid && is_load && (o_RT != 5'd0) && i_IFValid &&
                  (f_rs == o_RT || f_rt == o_RT);

  assign adv            = !o_Valid || i_EXReady;
  assign o_LoadUseStall = hazard;
  assign o_IFReady      = adv && !hazard && !i_Flush && !sys_rst;
  assign accept         = i_IFValid && o_IFReady;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[i_WBAddr] <= i_WBData;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      o_Valid     <= 1'b0;
      o_Opcode    <= '0;
      o_Function  <= '0;
      o_RS        <= '0;
      o_RT        <= '0;
      o_RD        <= '0;
      o_RSData    <= '0;
      o_RTData    <= '0;
      o_Immediate <= '0;
      o_PC        <= '0;
    end else if (i_Flush) begin
      o_Valid <= 1'b0;
    end else if (adv) begin
      o_Valid <= accept;
      if (accept) begin
        o_Opcode    <= f_op;
        o_Function  <= f_fn;
        o_RS        <= f_rs;
        o_RT        <= f_rt;
        o_RD        <= f_rd;
        o_RSData    <= rs_val;
        o_RTData    <= rt_val;
        o_Immediate <= imm_ext;
        o_PC        <= i_PC;
      end
    end else begin
      // Held operands track writeback so they are current when EX resumes
      if (wb_live && i_WBAddr == o_RS && o_RS != 5'd0)
        o_RSData <= i_WBData;
      if (wb_live && i_WBAddr == o_RT && o_RT != 5'd0)
        o_RTData <= i_WBData;
    end
  end

endmodule

// File: tb/tb_qm_decode.sv
// tb_qm_decode: directed scenarios plus a randomized run against a
// behavioural model of the decode stage.
module tb_qm_decode;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        ex_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];

  qm_decode dut (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .i_IFValid      (if_valid),
    .o_IFReady      (if_ready),
    .i_Instruction  (instr),
    .i_PC           (pc),
    .i_Flush        (flush),
    .i_EXReady      (ex_ready),
    .i_WBEnable     (wb_en),
    .i_WBAddr       (wb_addr),
    .i_WBData       (wb_data),
    .o_Valid        (valid),
    .o_Opcode       (opcode),
    .o_Function     (funct),
    .o_RS           (rs),
    .o_RT           (rt),
    .o_RD           (rd),
    .o_RSData       (rs_data),
    .o_RTData       (rt_data),
    .o_Immediate    (imm),
    .o_PC           (pc_out),
    .o_LoadUseStall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
  endtask

  function automatic logic [31:0] all_out();
    return {valid, opcode, funct, rs, rt, rd, stall} ^
           rs_data ^ rt_data ^ imm ^ pc_out;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    instr = '0;
    pc = '0;
    idle();
    tick();
    n_cmp++;
    if ({valid, opcode, funct, rs, rt, rd, rs_data, rt_data,
         imm, pc_out, stall} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b rs_data=%h pc=%h want all 0",
               valid, rs_data, pc_out);
    end
    n_cmp++;
    if (if_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ifready got %b want 0", if_ready);
    end
    rst = 1'b0;
    tick();
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1;
      wb_addr = 5'(i);
      wb_data = 32'h01010101 * i;
      tick();
    end
    wb_en = 1'b0;
    if_valid = 1'b1;
    instr = 32'h8C22_1234;
    pc = 32'h0000_0400;
    tick();
    if_valid = 1'b0;
    n_cmp++;
    if (valid !== 1'b1 || rs_data !== 32'h01010101) begin
      n_bad++;
      $display("FAIL pre_reset_load got valid=%b rs=%h want 1 01010101",
               valid, rs_data);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({valid, opcode, funct, rs, rt, rd, rs_data, rt_data,
         imm, pc_out, stall} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got valid=%b op=%h pc=%h imm=%h want all 0",
               valid, opcode, pc_out, imm);
    end
    n_cmp++;
    if (if_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_ifready got %b want 0", if_ready);
    end
    #1 rst = 1'b0;
    tick();
    for (int i = 1; i < 32; i++) begin
      instr = {6'd0, 5'(i), 5'(i), 16'h0020};
      if_valid = 1'b1;
      tick();
      n_cmp++;
      if ({rs_data, rt_data} !== 64'd0 || valid !== 1'b1) begin
        n_bad++;
        $display("FAIL cleared_r%0d got rs=%h rt=%h valid=%b want 0 0 1",
                 i, rs_data, rt_data, valid);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_rtype();
    idle();
    wb_en = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'h1234_5678;
    tick();
    wb_en = 1'b0;
    if_valid = 1'b1;
    instr = 32'h00A5_1821;
    pc = 32'h0000_1000;
    tick();
    if_valid = 1'b0;
    n_cmp++;
    if (valid !== 1'b1 || opcode !== 6'h00 || funct !== 6'h21 ||
        rd !== 5'd3 || pc_out !== 32'h0000_1000) begin
      n_bad++;
      $display("FAIL rtype_fields got v=%b op=%h fn=%h rd=%0d pc=%h want 1 00 21 3 1000",
               valid, opcode, funct, rd, pc_out);
    end
    n_cmp++;
    if (rs_data !== 32'h1234_5678 || rt_data !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL rtype_operands got rs=%h rt=%h want 12345678 12345678",
               rs_data, rt_data);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    wb_en = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'hDEAD_BEEF;
    if_valid = 1'b1;
    instr = 32'h00E0_4021;
    pc = 32'h0000_2000;
    tick();
    n_cmp++;
    if (valid !== 1'b1 || rs_data !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL bypass_rs got v=%b rs=%h want 1 deadbeef", valid, rs_data);
    end
    wb_addr = 5'd0;
    wb_data = 32'hFFFF_FFFF;
    instr = 32'h0000_4021;
    tick();
    n_cmp++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      n_bad++;
      $display("FAIL r0_bypass got rs=%h rt=%h want 0 0", rs_data, rt_data);
    end
    wb_en = 1'b0;
    tick();
    n_cmp++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      n_bad++;
      $display("FAIL r0_read got rs=%h rt=%h want 0 0", rs_data, rt_data);
    end
    idle();
    tick();
  endtask

  task automatic test_immediate();
    idle();
    if_valid = 1'b1;
    instr = 32'h2002_FFFF;
    tick();
    n_cmp++;
    if (imm !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL imm_addi got %h want ffffffff", imm);
    end
    instr = 32'h3402_FFFF;
    tick();
    n_cmp++;
    if (imm !== 32'h0000_FFFF) begin
      n_bad++;
      $display("FAIL imm_ori got %h want 0000ffff", imm);
    end
    instr = 32'h3002_8001;
    tick();
    n_cmp++;
    if (imm !== 32'h0000_8001) begin
      n_bad++;
      $display("FAIL imm_andi got %h want 00008001", imm);
    end
    instr = 32'h3802_7FFF;
    tick();
    n_cmp++;
    if (imm !== 32'h0000_7FFF) begin
      n_bad++;
      $display("FAIL imm_xori got %h want 00007fff", imm);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    if_valid = 1'b1;
    instr = 32'h8C22_0000;
    pc = 32'h0000_3000;
    tick();
    n_cmp++;
    if (valid !== 1'b1 || opcode !== 6'h23 || rt !== 5'd2) begin
      n_bad++;
      $display("FAIL lw_accept got v=%b op=%h rt=%0d want 1 23 2",
               valid, opcode, rt);
    end
    instr = 32'h0040_1821;
    pc = 32'h0000_3004;
    #1;
    n_cmp++;
    if (stall !== 1'b1 || if_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_detect got stall=%b ready=%b want 1 0", stall, if_ready);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_bubble got valid=%b want 0", valid);
    end
    n_cmp++;
    if (stall !== 1'b0 || if_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_release got stall=%b ready=%b want 0 1", stall, if_ready);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || funct !== 6'h21 || rs !== 5'd2 ||
        pc_out !== 32'h0000_3004) begin
      n_bad++;
      $display("FAIL lu_addu got v=%b fn=%h rs=%0d pc=%h want 1 21 2 3004",
               valid, funct, rs, pc_out);
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure_flush();
    logic [31:0] held;
    idle();
    if_valid = 1'b1;
    instr = 32'h00A5_1821;
    pc = 32'h0000_0100;
    tick();
    held = all_out();
    ex_ready = 1'b0;
    instr = 32'h0109_4020;
    pc = 32'h0000_0104;
    for (int k = 0; k < 3; k++) begin
      wb_en = (k == 1);
      wb_addr = 5'd5;
      wb_data = 32'hCAFE_F00D;
      #1;
      n_cmp++;
      if (if_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_ready_%0d got %b want 0", k, if_ready);
      end
      tick();
      n_cmp++;
      if (valid !== 1'b1 || pc_out !== 32'h0000_0100 || funct !== 6'h21) begin
        n_bad++;
        $display("FAIL bp_hold_%0d got v=%b pc=%h fn=%h want 1 100 21",
                 k, valid, pc_out, funct);
      end
      if (k == 0) begin
        n_cmp++;
        if (all_out() !== held) begin
          n_bad++;
          $display("FAIL bp_stable got %h want %h", all_out(), held);
        end
      end else begin
        n_cmp++;
        if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D) begin
          n_bad++;
          $display("FAIL bp_wb_update_%0d got rs=%h rt=%h want cafef00d",
                   k, rs_data, rt_data);
        end
      end
    end
    wb_en = 1'b0;
    flush = 1'b1;
    ex_ready = 1'b1;
    #1;
    n_cmp++;
    if (if_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready got %b want 0", if_ready);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_valid got %b want 0", valid);
    end
    flush = 1'b0;
    if_valid = 1'b0;
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_no_accept got %b want 0", valid);
    end
    idle();
    tick();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = 6'h00;
      2:       op = 6'h23;
      3:       op = 6'h20;
      4:       op = 6'h25;
      5:       op = 6'h0C;
      6:       op = 6'h0D;
      7:       op = 6'h0E;
      8:       op = 6'h08;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            16'($urandom)};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic test_random();
    logic        mv;
    logic [5:0]  mop;
    logic [5:0]  mfn;
    logic [4:0]  mrs;
    logic [4:0]  mrt;
    logic [4:0]  mrd;
    logic [31:0] mrsd;
    logic [31:0] mrtd;
    logic [31:0] mimm;
    logic [31:0] mpc;
    logic        hold;
    logic        adv;
    logic        ehz;
    logic        erdy;
    logic        mload;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    mv = 1'b0;
    {mop, mfn, mrs, mrt, mrd, mrsd, mrtd, mimm, mpc} = '0;
    hold = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!hold) begin
        instr = gen_instr();
        pc = $urandom;
      end
      if_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      wb_en = 1'($urandom_range(0, 1));
      wb_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) :
                                              5'($urandom_range(0, 3));
      wb_data = $urandom;
      #1;
      mload = (mop == 6'h20 || mop == 6'h21 || mop == 6'h23 ||
               mop == 6'h24 || mop == 6'h25);
      adv = !mv || ex_ready;
      ehz = mv && mload && mrt != 0 && if_valid &&
            (instr[25:21] == mrt || instr[20:16] == mrt);
      erdy = adv && !ehz && !flush;
      n_cmp++;
      if (stall !== ehz || if_ready !== erdy) begin
        n_bad++;
        $display("FAIL rand_comb_%0d got stall=%b ready=%b want %b %b",
                 c, stall, if_ready, ehz, erdy);
      end
      hold = if_valid && !erdy;
      @(posedge clk);
      if (flush) begin
        mv = 1'b0;
      end else if (adv) begin
        mv = if_valid && erdy;
        if (mv) begin
          mop  = instr[31:26];
          mrs  = instr[25:21];
          mrt  = instr[20:16];
          mrd  = instr[15:11];
          mfn  = instr[5:0];
          mrsd = model_read(mrs);
          mrtd = model_read(mrt);
          if (mop == 6'h0C || mop == 6'h0D || mop == 6'h0E)
            mimm = {16'h0, instr[15:0]};
          else
            mimm = {{16{instr[15]}}, instr[15:0]};
          mpc  = pc;
        end
      end else begin
        if (wb_en && wb_addr != 0 && wb_addr == mrs) mrsd = wb_data;
        if (wb_en && wb_addr != 0 && wb_addr == mrt) mrtd = wb_data;
      end
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      #1;
      n_cmp++;
      if (valid !== mv) begin
        n_bad++;
        $display("FAIL rand_valid_%0d got %b want %b", c, valid, mv);
      end
      if (mv) begin
        n_cmp++;
        if ({opcode, funct, rs, rt, rd} !== {mop, mfn, mrs, mrt, mrd} ||
            rs_data !== mrsd || rt_data !== mrtd ||
            imm !== mimm || pc_out !== mpc) begin
          n_bad++;
          $display("FAIL rand_fields_%0d got op=%h rs=%h rt=%h imm=%h pc=%h want %h %h %h %h %h",
                   c, opcode, rs_data, rt_data, imm, pc_out,
                   mop, mrsd, mrtd, mimm, mpc);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_bypass();
    test_immediate();
    test_load_use();
    test_backpressure_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
